uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the UART. Deserialises an 8N1-style frame from the `rx` line into a parallel word.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
- Presents the received word to the host with a valid/ack handshake and per-frame error flags.
- Sits beside the transmitter in the UART top level and shares its data type and baud-divider convention (clocks per bit).

Parameters:
- DATA_BITS, 8, number of data bits per frame; must equal the width of uart_data_t.
- DIV_W, 16, width of the baud divider input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  asynchronous serial line; idle high
- baud_div  input  DIV_W  clocks per bit; legal range >= 4
- rx_data  output  DATA_BITS  received word; stable while rx_valid=1
- rx_valid  output  1  word available; held until acknowledged
- rx_ack  input  1  host consumes word; only meaningful while rx_valid=1
- framing_err  output  1  stop bit of the presented word sampled low
- overrun  output  1  sticky; a frame completed while rx_valid=1
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, framing_err=0, overrun=0, busy=0, FSM=IDLE. Synchronizer flops reset to 1.
- Input path: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, giving 2 cycles of latency.
- Bit timer: counter cnt is cleared on every state change.
  - The bit event fires when cnt == div_q-1.
  - The half-bit event fires when cnt == (div_q>>1)-1.
- div_q latches baud_div on leaving IDLE. A baud_div change mid-frame takes effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE: rx_s==0 -> START.
  - START: on the half-bit event, sample rx_s.
    - If 0 -> DATA, with bit index idx=0.
    - If 1 -> IDLE (glitch rejected; nothing reported).
  - DATA: on each bit event, shift rx_s into the shift register at position idx (LSB first), then idx++.
    - After bit DATA_BITS-1 -> PARITY if the feature is enabled, else STOP.
    - Sampling points are therefore the centres of the bits.
  - STOP: on the bit event, sample rx_s, then go to IDLE in the same cycle.
    - The next start bit can be detected the following cycle, so back-to-back frames are supported.
- Completion, in the cycle after the STOP sample:
  - rx_data <= shift register.
  - framing_err <= ~stop_sample.
  - rx_valid <= 1.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid on the next edge.
  - rx_ack while rx_valid=0 is ignored.
- Overrun: completion while rx_valid=1 and no rx_ack in the same cycle.
  - Sets overrun.
  - Discards the new word; rx_data and framing_err keep the old frame.
  - overrun clears on rx_ack.
- Completion coincident with rx_ack: the new word loads, rx_valid stays 1, and overrun is not set.
- A frame with framing_err=1 is still delivered.
- Reset asserted mid-frame: every register returns to its reset value immediately. A partially received frame is lost, and no rx_valid is produced after release.
- A line held low (break) produces one frame of zeros with framing_err=1. The FSM then re-enters START only after rx_s returns high and falls again.
  - To implement this, IDLE requires one observed rx_s==1 since the last STOP.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state, one bit time after the last data bit.
  - Adds input parity_odd (1 = odd parity, 0 = even) and output parity_err.
  - parity_err = received parity != XOR of the data bits XOR parity_odd.
  - parity_err is loaded and discarded together with rx_data/framing_err. Reset value 0.
- Undefined: no PARITY state, no parity_odd/parity_err ports; the frame is start + data + stop.

Decomposition:
- UART_pkg holds the shared definitions:
  - uart_data_t, shared with the transmitter.
  - A uart_rx_state_e enum.
  - A UART_MIN_BAUD_DIV constant = 4.
- Sub-module uart_rx_sync: the 2-flop synchronizer with reset-to-1, instanced once. The FSM, timer and datapath stay in uart_rx.

Test Plan:
- baud_div=16, send 0xA5 -> rx_data=0xA5, rx_valid rises 2+8+9*16+1 = 155 cycles after the rx falling edge, framing_err=0; rx_ack -> rx_valid=0 next cycle.
- baud_div=16, rx low for 5 cycles then high -> no rx_valid, busy returns 0 within 10 cycles.
- Send 0x3C with the stop bit driven low -> rx_data=0x3C, framing_err=1.
- Send 0x11 then 0x22 back-to-back with no ack -> rx_data=0x11, overrun=1; ack -> overrun=0. Repeat with ack pulsed in the second frame's completion cycle -> rx_data=0x22, overrun=0.
- Assert rst_n=0 during data bit 4 of a frame -> all outputs 0 immediately. A clean frame 0x5A after release is received correctly.
- With UART_RX_PARITY_EN, parity_odd=0:
  - Send 0x07 with parity bit 1 -> parity_err=0.
  - Send 0x07 with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (data word, receiver states, divider floor)
// Imported by the transmitter and the receiver so both agree on word width.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_MIN_BAUD_DIV = 4;

  typedef logic [UART_DATA_BITS-1:0] uart_data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

  // Expected parity bit for a word: XOR of the data, inverted for odd parity.
  function automatic logic uart_parity(input uart_data_t d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART serial receiver with valid/ack handshake and error flags
// Optional parity state and ports enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 framing_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int              IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(UART_MIN_BAUD_DIV);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  if (DATA_BITS != $bits(uart_data_t)) begin : g_width_check
    $error("uart_rx: DATA_BITS must match uart_data_t");
  end

  uart_rx_state_e       state;
  logic                 rx_s;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_q;
  logic [IDX_W-1:0]     idx;
  uart_data_t           shift_q;
  logic                 stop_q;
  logic                 done;
  logic                 armed;
  logic                 bit_evt;
  logic                 half_evt;
  logic                 ack_hit;
  logic                 drop;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_evt  = (cnt == div_q - ONE);
  assign half_evt = (cnt == (div_q >> 1) - ONE);
  assign ack_hit  = rx_valid & rx_ack;
  // A completion is dropped only if the old word is still unread after this edge.
  assign drop     = rx_valid & ~rx_ack;

  // Frame FSM, bit timer and shift register. armed blocks a held-low line
  // from retriggering until it has been seen high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_q   <= '0;
      idx     <= '0;
      shift_q <= '0;
      stop_q  <= 1'b1;
      done    <= 1'b0;
      armed   <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt  <= cnt + ONE;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= ST_START;
            div_q <= (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (half_evt) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bit_evt) begin
            cnt          <= '0;
            shift_q[idx] <= rx_s;
            idx          <= idx + 1'b1;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_evt) begin
            cnt   <= '0;
            par_q <= rx_s;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_evt) begin
            cnt    <= '0;
            stop_q <= rx_s;
            armed  <= rx_s;
            done   <= 1'b1;
            state  <= ST_IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Host-facing word register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (done && drop) begin
        overrun <= 1'b1;
      end else if (ack_hit) begin
        overrun <= 1'b0;
      end

      if (done && !drop) begin
        rx_data     <= shift_q;
        framing_err <= ~stop_q;
        rx_valid    <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err  <= par_q ^ uart_parity(shift_q, parity_odd);
`endif
      end else if (ack_hit) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        framing_err;
  logic        overrun;
  logic        busy;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd = 1'b0;
  logic        parity_err;
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .baud_div    (baud_div),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .framing_err (framing_err),
    .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_odd  (parity_odd),
    .parity_err  (parity_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold_bit(input logic b);
    rx = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after an edge with the line idle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(pbit);
`endif
    hold_bit(stop);
    rx = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_ferr", framing_err, 0);
    check("reset_ovr", overrun, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        int n = 0;
        @(posedge clk);
        #1;
        while (!rx_valid && n < 400) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("a5_latency", n, LAT);
      end
    join
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_ferr", framing_err, 0);
    check("a5_ovr", overrun, 0);
    do_ack();
    check("a5_ack_clears", rx_valid, 0);

    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_hi", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    check("glitch_busy_lo", busy, 0);
    repeat (200) @(posedge clk);
    #1;
    check("glitch_no_valid", rx_valid, 0);

    send_frame(8'h3C, 1'b0, 1'b0);
    check("3c_valid", rx_valid, 1);
    check("3c_data", rx_data, 8'h3C);
    check("3c_ferr", framing_err, 1);

    // Reset lands in data bit 4 while the 0x3C word is still presented.
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        repeat (88) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_busy", busy, 0);
      end
    join
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("post_rst_no_valid", rx_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("5a_valid", rx_valid, 1);
    check("5a_data", rx_data, 8'h5A);
    check("5a_ferr", framing_err, 0);
    do_ack();

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", rx_valid, 1);
    do_ack();
    check("ovr_ack_clears", overrun, 0);
    check("ovr_ack_valid", rx_valid, 0);

    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (LAT) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        check("coinc_valid", rx_valid, 1);
      end
    join
    check("coinc_data", rx_data, 8'h22);
    check("coinc_ovr", overrun, 0);
    do_ack();

    rx = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("break_valid", rx_valid, 1);
    check("break_data", rx_data, 0);
    check("break_ferr", framing_err, 1);
    check("break_busy", busy, 0);
    do_ack();
    repeat (200) @(posedge clk);
    #1;
    check("break_no_refire", rx_valid, 0);
    check("break_idle", busy, 0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_data", rx_data, 8'h07);
    check("par_ok_err", parity_err, 0);
    do_ack();
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_err", parity_err, 1);
    check("par_bad_valid", rx_valid, 1);
    do_ack();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
